// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO sequencing controller for MULT/DIV/MTHI/MTLO: launches the external multiplier or divider,
// holds the operands stable while it runs, and writes the result into HI/LO unless cancelled.
//  state    | meaning
//  IDLE     | no operation in flight, can accept
//  MUL_WAIT | multiplier running, cnt counts cycles up to MUL_LAT
//  DIV_RUN  | iterative divider running, waiting for div_complete
module muldiv_hilo_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_type,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        mul_start,
    output logic        md_signed,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_low,
    output logic        div_start,
    output logic        div_abort,
    input  logic        div_complete,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_low,
    output logic [31:0] hi_reg,
    output logic [31:0] low_reg,
    output logic        busy,
    output logic        op_done
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN} state_t;

    localparam logic [3:0] LAT = 4'(MUL_LAT);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] md_a_q, md_b_q, hi_nxt, low_nxt;
    logic        md_signed_q;
    logic        accept, is_mul, is_div, is_mthi, is_mtlo, div_zero, op_signed;
    logic        mul_fin, div_fin, launch;

    assign is_mul    = (op_type == 3'd0) || (op_type == 3'd1);
    assign is_div    = (op_type == 3'd2) || (op_type == 3'd3);
    assign is_mthi   = (op_type == 3'd4);
    assign is_mtlo   = (op_type == 3'd5);
    assign op_signed = (op_type == 3'd0) || (op_type == 3'd2);
    assign div_zero  = (src_b == 32'd0);

    // rst_n in the ready term keeps ready low for the whole time reset is held
    assign op_ready  = (state == IDLE) && !cancel && rst_n;
    assign accept    = op_valid && op_ready;
    assign busy      = (state != IDLE);

    assign mul_start = accept && is_mul;
    assign div_start = accept && is_div && !div_zero;
    assign launch    = mul_start || div_start;
    assign div_abort = (state == DIV_RUN) && cancel;

    assign mul_fin   = (state == MUL_WAIT) && (cnt == LAT) && !cancel;
    assign div_fin   = (state == DIV_RUN) && div_complete && !cancel;
    assign op_done   = mul_fin || div_fin || (accept && is_div && div_zero);

    // Operands are visible in the launch cycle, then held from the capture registers
    assign md_a      = launch ? src_a : md_a_q;
    assign md_b      = launch ? src_b : md_b_q;
    assign md_signed = launch ? op_signed : md_signed_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    state_nxt = MUL_WAIT;
                    cnt_nxt   = 4'd1;
                end else if (div_start) begin
                    state_nxt = DIV_RUN;
                end
            end
            MUL_WAIT: begin
                if (cancel || (cnt == LAT)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DIV_RUN: begin
                if (cancel || div_complete) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        hi_nxt  = hi_reg;
        low_nxt = low_reg;
        if (accept && is_mthi) begin
            hi_nxt = src_a;
        end
        if (accept && is_mtlo) begin
            low_nxt = src_a;
        end
        if (mul_fin) begin
            hi_nxt  = mul_hi;
            low_nxt = mul_low;
        end
        if (div_fin) begin
            hi_nxt  = div_hi;
            low_nxt = div_low;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            hi_reg      <= 32'd0;
            low_reg     <= 32'd0;
            md_a_q      <= 32'd0;
            md_b_q      <= 32'd0;
            md_signed_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_reg  <= hi_nxt;
            low_reg <= low_nxt;
            if (launch) begin
                md_a_q      <= src_a;
                md_b_q      <= src_b;
                md_signed_q <= op_signed;
            end
        end
    end

endmodule

// File: doc/muldiv_hilo_ctrl.md
MULDIV_HILO_CTRL -- requirements
Module: muldiv_hilo_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 2, SHALL be the external multiplier latency in cycles, from mul_start to a valid mul_hi/mul_low; legal range 1..15.
REQ-002 clock  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  SHALL be asynchronous and active-low (0 = reset).
REQ-004 op_valid  in  1  upstream holds a HI/LO-class operation.
REQ-005 op_ready  out  1  block can accept an operation this cycle.
REQ-006 op_type  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 SHALL be accepted and ignored (no-op).
REQ-007 src_a, src_b  in  32 each  operands; MTHI/MTLO SHALL use src_a.
REQ-008 cancel  in  1  pipeline flush (exception or ERET in a later stage).
REQ-009 mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-010 md_signed  out  1  signed mode for the started operation.
REQ-011 md_a, md_b  out  32 each  operands for the started operation.
REQ-012 mul_hi, mul_low  in  32 each  multiplier result.
REQ-013 div_start  out  1  one-cycle start pulse to the iterative divider.
REQ-014 div_abort  out  1  one-cycle kill pulse to the divider.
REQ-015 div_complete, div_hi, div_low  in  1/32/32  divider done pulse, remainder, quotient.
REQ-016 hi_reg, low_reg  out  32 each  architectural HI and LO.
REQ-017 busy  out  1  an operation is in flight; the pipeline SHALL stall MFHI/MFLO while it is high.
REQ-018 op_done  out  1  one-cycle pulse in the cycle HI/LO are written by MUL or DIV.

Function
REQ-019 FSM states SHALL be IDLE, MUL_WAIT and DIV_RUN; busy = (state != IDLE).
REQ-020 op_ready SHALL equal (state == IDLE) & ~cancel.
REQ-021 An operation is accepted when op_valid & op_ready are both high.
REQ-022 MTHI/MTLO accepted at edge T SHALL write src_a to hi_reg/low_reg at T; state stays IDLE and op_done stays low.
REQ-023 On MULT/MULTU acceptance:
  - mul_start SHALL be high combinationally in the accept cycle; md_a/md_b/md_signed SHALL be driven from the inputs in that cycle.
  - At the edge the state SHALL go to MUL_WAIT with counter = 1.
  - In MUL_WAIT the counter SHALL increment each cycle.
  - In the cycle where counter == MUL_LAT, hi_reg<=mul_hi and low_reg<=mul_low at the next edge, op_done=1, and the state SHALL return to IDLE.
  - Result write therefore occurs MUL_LAT+1 edges after acceptance.
REQ-024 On DIV/DIVU acceptance with src_b != 0:
  - div_start SHALL pulse in the accept cycle.
  - The state SHALL go to DIV_RUN.
  - In DIV_RUN with div_complete=1: hi_reg<=div_hi, low_reg<=div_low, op_done=1, return to IDLE.
REQ-025 DIV/DIVU with src_b == 0 SHALL:
  - not pulse div_start;
  - leave HI/LO unchanged;
  - stay IDLE;
  - pulse op_done in the accept cycle.
REQ-026 div_complete outside DIV_RUN SHALL be ignored.
REQ-027 Operand capture: md_a, md_b and md_signed SHALL be registered at acceptance and held stable while busy.
REQ-028 cancel in MUL_WAIT or DIV_RUN:
  - The state SHALL go to IDLE at the next edge, with no HI/LO write and no op_done.
  - In DIV_RUN, div_abort SHALL pulse in that cycle.
REQ-029 cancel coinciding with div_complete, or with counter == MUL_LAT, SHALL win; no write.
REQ-030 A cancel in the same cycle as an IDLE-state MTHI/MTLO SHALL suppress the write (op_ready=0).
REQ-031 The counter SHALL be 4 bits wide and SHALL only count in MUL_WAIT.

Reset
REQ-032 While reset=0, the block SHALL hold:
  - state=IDLE, counter=0;
  - hi_reg=low_reg=0, md_a=md_b=0, md_signed=0;
  - all pulses low;
  - op_ready=0 (the reset term forces it low).
REQ-033 Reset asserted mid-operation SHALL abandon it; no HI/LO write after release.
REQ-034 After reset release, the first edge SHALL already accept an operation.

Verification
REQ-035 MTHI src_a=0x12345678, then MTLO src_a=0x9ABCDEF0 -> hi_reg=0x12345678 and low_reg=0x9ABCDEF0 one edge after each accept; busy never high.
REQ-036 MULT with MUL_LAT=2, model returning mul_hi=0xFFFFFFFF and mul_low=0xFFFFFFFE -> mul_start 1 cycle, busy 2 cycles, op_done on the 3rd cycle, HI/LO updated on the 3rd edge.
REQ-037 DIVU 100/7, divider model completes after 33 cycles with div_hi=2 and div_low=14 -> HI=2, LO=14; op_ready low throughout DIV_RUN.
REQ-038 DIV with src_b=0 and HI/LO preloaded to 0xA/0xB -> no div_start, op_done pulse, HI/LO remain 0xA/0xB.
REQ-039 DIV started, then cancel asserted in the same cycle as div_complete -> div_abort pulse, no op_done, HI/LO unchanged, IDLE next cycle.
REQ-040 reset pulled low for 1 cycle mid-MUL_WAIT -> all outputs zero immediately (asynchronous); a later mul_hi value is never written.
